axi_master_arbiter: RTL

- Round-robin command scheduler that shares one axi_master between NUM_REQ requesters.
- Accepts one command per requester and drives the master's top-side command inputs (transfer, write_en/read_en, address/id/len/size/burst).
- Holds the command stable until the master reports completion, then returns response status to the owning requester.
- Sits between client logic and axi_master in the AXI top; write data and read data are muxed outside, using `grant`.

---
 rtl/axi_master_arbiter_pkg.sv | 26 ++
 rtl/axi_master_arbiter_if.sv | 54 +++++
 rtl/axi_rr_pick.sv | 38 +++
 rtl/axi_master_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/axi_master_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module      : axi_master_arbiter_pkg
// Description : Shared AXI width constants, arbiter state encoding and the
//               SLVERR response code used by the round-robin command arbiter.
// Revision    : 1.0 - initial release
//============================================================================
package axi_master_arbiter_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int ID_WIDTH    = 4;
    localparam int LEN_WIDTH   = 8;
    localparam int SIZE_WIDTH  = 3;
    localparam int BURST_WIDTH = 2;
    localparam int RESP_WIDTH  = 2;

    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_BUSY  = 2'b10
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_master_arbiter_if.sv
`default_nettype none
//============================================================================
// Module      : axi_master_arbiter_if
// Description : Requester-side and master-side command/completion signals of
//               the arbiter. Modport master = arbiter view, slave = environment.
// Revision    : 1.0 - initial release
//============================================================================
interface axi_master_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import axi_master_arbiter_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
    logic [NUM_REQ*ID_WIDTH-1:0]    req_id;
    logic [NUM_REQ*LEN_WIDTH-1:0]   req_len;
    logic [NUM_REQ*SIZE_WIDTH-1:0]  req_size;
    logic [NUM_REQ*BURST_WIDTH-1:0] req_burst;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             done;
    logic [RESP_WIDTH-1:0]          resp;
    logic                           timeout_err;

    logic                           transfer;
    logic                           write_en;
    logic                           read_en;
    logic [ADDR_WIDTH-1:0]          cmd_addr;
    logic [ID_WIDTH-1:0]            cmd_id;
    logic [LEN_WIDTH-1:0]           cmd_len;
    logic [SIZE_WIDTH-1:0]          cmd_size;
    logic [BURST_WIDTH-1:0]         cmd_burst;
    logic                           wr_done;
    logic [RESP_WIDTH-1:0]          wr_resp;
    logic                           rd_done;
    logic [RESP_WIDTH-1:0]          rd_resp;

    modport master (
        input  req_valid, req_write, req_addr, req_id, req_len, req_size, req_burst,
        input  wr_done, wr_resp, rd_done, rd_resp,
        output req_ready, grant, done, resp, timeout_err,
        output transfer, write_en, read_en, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst
    );

    modport slave (
        output req_valid, req_write, req_addr, req_id, req_len, req_size, req_burst,
        output wr_done, wr_resp, rd_done, rd_resp,
        input  req_ready, grant, done, resp, timeout_err,
        input  transfer, write_en, read_en, cmd_addr, cmd_id, cmd_len, cmd_size, cmd_burst
    );

endinterface
`default_nettype wire

// File: rtl/axi_rr_pick.sv
`default_nettype none
//============================================================================
// Module      : axi_rr_pick
// Description : Combinational round-robin picker; search starts at i_ptr and
//               wraps modulo NUM_REQ. Returns one-hot winner and its index.
// Revision    : 1.0 - initial release
//============================================================================
module axi_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_win_onehot,
    output logic [PTR_W-1:0]   o_win_idx
);

    // Walk from the farthest offset back to the pointer so the closest
    // requester is the last one written and therefore wins.
    always_comb begin
        o_win_onehot = '0;
        o_win_idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int c;
            c = int'(i_ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (i_req[c]) begin
                o_win_onehot    = '0;
                o_win_onehot[c] = 1'b1;
                o_win_idx       = PTR_W'(c);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_master_arbiter.sv
`default_nettype none
//============================================================================
// Module      : axi_master_arbiter
// Description : Round-robin scheduler sharing one axi_master among NUM_REQ
//               requesters. Optional watchdog: define AXI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//============================================================================
module axi_master_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_master_arbiter_if.master bus
);

    generate
        if (NUM_REQ < 1 || NUM_REQ > 8 || (2 ** PTR_W) < NUM_REQ || TIMEOUT < 2) begin : g_bad_cfg
            $error("axi_master_arbiter: invalid NUM_REQ / PTR_W / TIMEOUT");
        end
    endgenerate

    arb_state_t             r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_owner;
    logic                   r_is_write;

    logic [NUM_REQ-1:0]     w_win_onehot;
    logic [PTR_W-1:0]       w_win_idx;
    logic                   w_cpl;
    logic                   w_tmo;
    logic [RESP_WIDTH-1:0]  w_cpl_resp;
    logic [PTR_W-1:0]       w_next_ptr;

    axi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req        (bus.req_valid),
        .i_ptr        (r_ptr),
        .o_win_onehot (w_win_onehot),
        .o_win_idx    (w_win_idx)
    );

    // Only the done matching the owner's direction counts.
    assign w_cpl      = r_is_write ? bus.wr_done : bus.rd_done;
    assign w_cpl_resp = r_is_write ? bus.wr_resp : bus.rd_resp;
    assign w_next_ptr = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);

`ifdef AXI_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT);

    logic [TMR_W-1:0] r_timer;
    logic             r_tmo_err;

    assign w_tmo = (r_timer == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_timer   <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_timer <= (r_state == ARB_BUSY) ? r_timer + TMR_W'(1) : '0;
            if (r_state == ARB_BUSY && w_tmo && !w_cpl) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign bus.timeout_err = r_tmo_err;
`else
    assign w_tmo           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ARB_IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_is_write    <= 1'b0;
            bus.req_ready <= '0;
            bus.grant     <= '0;
            bus.done      <= '0;
            bus.resp      <= '0;
            bus.transfer  <= 1'b0;
            bus.write_en  <= 1'b0;
            bus.read_en   <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_id    <= '0;
            bus.cmd_len   <= '0;
            bus.cmd_size  <= '0;
            bus.cmd_burst <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.done      <= '0;
            bus.transfer  <= 1'b0;
            bus.write_en  <= 1'b0;
            bus.read_en   <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (|bus.req_valid) begin
                        r_owner       <= w_win_idx;
                        r_is_write    <= |(bus.req_write & w_win_onehot);
                        bus.req_ready <= w_win_onehot;
                        bus.grant     <= w_win_onehot;
                        bus.transfer  <= 1'b1;
                        bus.write_en  <= |(bus.req_write & w_win_onehot);
                        bus.read_en   <= ~|(bus.req_write & w_win_onehot);
                        bus.cmd_addr  <= bus.req_addr[int'(w_win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                        bus.cmd_id    <= bus.req_id[int'(w_win_idx) * ID_WIDTH +: ID_WIDTH];
                        bus.cmd_len   <= bus.req_len[int'(w_win_idx) * LEN_WIDTH +: LEN_WIDTH];
                        bus.cmd_size  <= bus.req_size[int'(w_win_idx) * SIZE_WIDTH +: SIZE_WIDTH];
                        bus.cmd_burst <= bus.req_burst[int'(w_win_idx) * BURST_WIDTH +: BURST_WIDTH];
                        r_state       <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    r_state <= ARB_BUSY;
                end
                ARB_BUSY: begin
                    // cmd_* and grant stay put: the master reads them combinationally.
                    if (w_cpl || w_tmo) begin
                        bus.done  <= bus.grant;
                        bus.resp  <= w_cpl ? w_cpl_resp : RESP_SLVERR;
                        bus.grant <= '0;
                        r_ptr     <= w_next_ptr;
                        r_state   <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
